fizz_buzz_gen: RTL and testbench

FIZZ_BUZZ_GEN -- requirements
Module: fizz_buzz_gen

---
 rtl/fizzbuzz_pkg.sv | 11 +
 rtl/mod_counter.sv | 29 ++
 rtl/fizz_buzz_gen.sv | 113 +++++++++++
 tb/tb_fizz_buzz_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared constants and state encoding for the fizz/buzz sequence generator.
package fizzbuzz_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter: loads 1, wraps MOD-1 -> 0 on inc, flags a zero count.
module mod_counter #(
  parameter int MOD = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic                                  inc,
  output logic [((MOD > 1) ? $clog2(MOD) : 1)-1:0] cnt,
  output logic                                  zero
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1 % MOD);
    end else if (inc) begin
      cnt <= (cnt == CW'(MOD - 1)) ? '0 : cnt + CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fizz_buzz_gen.sv
// Streams n = 1..limit with divisible-by-3/5 flags over a valid/ready handshake.
module fizz_buzz_gen
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] n,
  output logic             fizz,
  output logic             buzz,
  output logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] limit_q;
  logic             load;
  logic             advance;
  logic             done;
  logic             running;
  logic             at_last;
  logic [1:0]       m3_cnt;
  logic [2:0]       m5_cnt;
  logic             m3_zero;
  logic             m5_zero;
  logic             unused_cnt;

  assign running = (state_q == RUN);
  assign at_last = (n_q == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (limit != '0)) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // n is bounded by the captured limit, so it can never wrap past all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= '0;
      limit_q <= '0;
    end else if (load) begin
      n_q     <= WIDTH'(1);
      limit_q <= limit;
    end else if (advance) begin
      n_q <= n_q + WIDTH'(1);
    end else if (done) begin
      n_q <= '0;
    end
  end

  mod_counter #(.MOD(3)) u_mod3 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .inc  (advance),
    .cnt  (m3_cnt),
    .zero (m3_zero)
  );

  mod_counter #(.MOD(5)) u_mod5 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .inc  (advance),
    .cnt  (m5_cnt),
    .zero (m5_zero)
  );

  // Raw counts are only needed through their zero flags.
  assign unused_cnt = ^{m3_cnt, m5_cnt};

  assign out_valid = running;
  assign busy      = running;
  assign n         = running ? n_q : '0;
  assign fizz      = running && m3_zero;
  assign buzz      = running && m5_zero;
  assign last      = running && at_last;

endmodule

// File: tb/tb_fizz_buzz_gen.sv
// Directed self-checking bench for fizz_buzz_gen (WIDTH = 8).
module tb_fizz_buzz_gen;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] n;
  logic             fizz;
  logic             buzz;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int passed = 0;
  int total  = 0;

  fizz_buzz_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .limit     (limit),
    .n         (n),
    .fizz      (fizz),
    .buzz      (buzz),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(out_valid), 0);
    check({tag, " busy"},  32'(busy), 0);
    check({tag, " n"},     32'(n), 0);
  endtask

  // Full beat check with ready high; expected flags derived from the value.
  task automatic check_beat(input string tag, input int v, input int lim);
    check({tag, " valid"}, 32'(out_valid), 1);
    check({tag, " n"},     32'(n), 32'(v));
    check({tag, " fizz"},  32'(fizz), 32'(v % 3 == 0));
    check({tag, " buzz"},  32'(buzz), 32'(v % 5 == 0));
    check({tag, " last"},  32'(last), 32'(v == lim));
  endtask

  initial begin
    int exp_n;
    int xfers;
    int zero_seen;
    bit rdy_pat [4];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; limit = '0; out_ready = 1'b0;
    #12;
    check_idle("reset");
    check("reset fizz", 32'(fizz), 0);
    check("reset last", 32'(last), 0);
    rst = 1'b0;
    tick();

    // limit == 0 is ignored.
    start = 1'b1; limit = 8'd0;
    tick();
    start = 1'b0;
    check_idle("lim0");
    tick();
    check_idle("lim0 later");

    // limit 15, ready held high.
    start = 1'b1; limit = 8'd15; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int v = 1; v <= 15; v++) begin
      check_beat($sformatf("l15 n=%0d", v), v, 15);
      tick();
    end
    check_idle("l15 end");

    // limit 6 with ready pattern 1,0,0,1: stalls hold, no skips or repeats.
    start = 1'b1; limit = 8'd6; out_ready = 1'b0;
    tick();
    start = 1'b0;
    exp_n = 1; xfers = 0;
    for (int k = 0; k < 40 && out_valid; k++) begin
      check($sformatf("l6 n k=%0d", k), 32'(n), 32'(exp_n));
      check($sformatf("l6 last k=%0d", k), 32'(last), 32'(exp_n == 6));
      out_ready = rdy_pat[k % 4];
      tick();
      if (out_ready) begin
        exp_n++;
        xfers++;
      end
    end
    check("l6 transfers", 32'(xfers), 6);
    check_idle("l6 end");
    out_ready = 1'b1;

    // limit 255: full range, no wrap to 0.
    start = 1'b1; limit = 8'd255;
    tick();
    start = 1'b0;
    zero_seen = 0;
    for (int v = 1; v <= 255; v++) begin
      if (v == 255) check_beat("l255 final", v, 255);
      else check($sformatf("l255 n=%0d", v), 32'(n), 32'(v));
      tick();
    end
    check_idle("l255 end");

    // Async reset mid-sequence at n=7.
    start = 1'b1; limit = 8'd20;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_beat("l20 n=7", 7, 20);
    #2 rst = 1'b1;
    #1;
    check_idle("async rst");
    rst = 1'b0;
    tick();
    check_idle("after rst");
    start = 1'b1; limit = 8'd3;
    tick();
    start = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      check_beat($sformatf("l3 n=%0d", v), v, 3);
      tick();
    end
    check_idle("l3 end");

    // start held, limit changed mid-run; start ignored on last-beat edge.
    start = 1'b1; limit = 8'd4;
    tick();
    limit = 8'd9;
    for (int v = 1; v <= 4; v++) begin
      check_beat($sformatf("l4 n=%0d", v), v, 4);
      tick();
    end
    check_idle("l4 end");
    tick();
    start = 1'b0;
    check_beat("restart n=1", 1, 9);
    exp_n = 1;
    for (int k = 0; k < 20 && out_valid && !last; k++) begin
      tick();
      exp_n++;
    end
    check("restart end n", 32'(n), 9);
    check("restart end last", 32'(last), 1);
    check("restart count", 32'(exp_n), 9);
    tick();
    check_idle("restart done");
    if (zero_seen != 0) check("l255 zero beat", 32'(zero_seen), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Any valid beat showing n == 0 is an error regardless of the test phase.
  always @(negedge clk) begin
    if (out_valid && n == '0) begin
      total++;
      $error("FAIL valid_zero: observed n %0d with valid, required nonzero", n);
    end
  end

endmodule
